uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that serialises one data word per frame with configurable data width, optional parity, 1 or 2 stop bits, and configurable baud-tick oversampling.
- `din` is latched into an internal shift register when `start` is accepted, so upstream may change it mid-frame.
- The block sits between the system baud-tick generator and the TX pin, next to the UART RX and TX FIFO.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, baud_tick pulses per serial bit; legal 4..32.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- baud_tick  input  1  single-cycle pulse at OVERSAMPLE × baud rate.
- start  input  1  request to send din; level-sampled, accepted only in IDLE.
- din  input  DATA_W  word to send, LSB transmitted first.
- o_tx_ready  output  1  1 when in IDLE and able to accept start.
- o_tx_busy  output  1  1 from the cycle after acceptance until frame end.
- o_tx_done  output  1  one-cycle pulse at frame completion.
- o_tx  output  1  serial line; idle high.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: o_tx=1, o_tx_busy=0, o_tx_done=0, o_tx_ready=1, state=IDLE, all counters 0. Reset mid-frame aborts immediately; o_tx returns high asynchronously.
- All outputs are registered, except o_tx_ready = (state==IDLE), which is combinational from the state register.
- State machine: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
- IDLE:
  - o_tx=1, busy=0.
  - On start=1: latch din into shift register, compute parity, clear tick and bit counters, go to START.
  - busy=1 and o_tx=0 take effect on the next clock edge, i.e. one-cycle latency from start to line low.
- Tick counter (width $clog2(OVERSAMPLE*STOP_BITS)):
  - Increments only on baud_tick.
  - A bit ends on the baud_tick for which counter == OVERSAMPLE-1. The counter wraps to 0 there and the state/bit advance.
  - Cycles without baud_tick hold all state.
- START: o_tx=0 for exactly OVERSAMPLE ticks.
- DATA:
  - o_tx = shift[0]; the register shifts right at each bit end.
  - Bit counter (width $clog2(DATA_W)) counts 0..DATA_W-1.
  - After bit DATA_W-1, go to PARITY (if enabled) else STOP.
- PARITY:
  - o_tx = ^data_latched XOR PARITY_ODD, held for OVERSAMPLE ticks.
  - Parity is computed from the latched word, not from live din.
- STOP:
  - o_tx=1 for STOP_BITS × OVERSAMPLE ticks.
  - On the final tick: next state IDLE, o_tx_done=1 for one cycle, o_tx_busy=0 in that same cycle.
- Frame length: exactly (1 + DATA_W + PARITY_EN + STOP_BITS) × OVERSAMPLE baud ticks.
- start while busy is ignored, with no queuing.
- Back-to-back frames: start held high is re-accepted in the cycle the state is IDLE. The minimum line-high gap is the stop bit(s) plus one clk cycle.
- A baud_tick coincident with start acceptance is not counted. Counting begins in START.
- din changes during a frame have no effect on o_tx.
- o_tx_done is 0 in every cycle except the single completion cycle.

Test Plan:
1. 8N1, OVERSAMPLE=16, baud_tick every 4th clk, start pulse with din=0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held 16 ticks = 64 clk. Total 160 ticks. o_tx_done pulses once at tick 160. busy high ticks 0..159.
2. DATA_W=8, PARITY_EN=1, PARITY_ODD=0, din=0x07 -> parity bit = 1. Frame 11 bits = 176 ticks. With PARITY_ODD=1 the same din gives parity bit = 0.
3. DATA_W=7, PARITY_ODD=1, STOP_BITS=2, din=0x00 -> 7 zero data bits, parity=1, 32 ticks of stop high. done at tick 176.
4. Frame 0xA3 in progress; mid-DATA, din changes to 0xFF and start pulses -> transmitted bits stay 0xA3, no second frame, o_tx_ready=0 throughout.
5. start held high continuously, din=0x81 -> two consecutive identical frames. Gap between first stop end and second start bit is exactly one clk. Two done pulses.
6. Assert rst during DATA bit 3 -> o_tx=1, busy=0, done=0 immediately. After release, ready=1 and a new start sends a full frame correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits.
// Each serial bit lasts OVERSAMPLE baud_tick pulses; din is latched at start.
module uart_tx_cfg #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              o_tx_ready,
  output logic              o_tx_busy,
  output logic              o_tx_done,
  output logic              o_tx
);

  localparam int TW = $clog2(OVERSAMPLE * STOP_BITS);
  localparam int BW = $clog2(DATA_W);

  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END = TW'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State register; reset drops any frame and forces the line idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: bits advance only on the baud_tick that ends a bit period.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d = din;
          par_d   = (^din) ^ ODD;
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            state_d = S_DATA;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
              if (HAS_PAR) begin
                state_d = S_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = S_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = shift_q[1];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (tick_q == STOP_END) begin
            tick_d  = '0;
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_tx_ready = (state_q == S_IDLE);
  assign o_tx_busy  = busy_q;
  assign o_tx_done  = done_q;
  assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three configurations driven with random baud ticks.
// Expected line bits are built per frame from the word and frame format.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       start [3];
  logic [8:0] din   [3];
  logic       tx    [3];
  logic       busy  [3];
  logic       done  [3];
  logic       ready [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_W(8), .OVERSAMPLE(16), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .start(start[0]), .din(din[0][7:0]),
    .o_tx_ready(ready[0]), .o_tx_busy(busy[0]),
    .o_tx_done(done[0]), .o_tx(tx[0])
  );

  uart_tx_cfg #(
    .DATA_W(7), .OVERSAMPLE(4), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .start(start[1]), .din(din[1][6:0]),
    .o_tx_ready(ready[1]), .o_tx_busy(busy[1]),
    .o_tx_done(done[1]), .o_tx(tx[1])
  );

  uart_tx_cfg #(
    .DATA_W(8), .OVERSAMPLE(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_c (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .start(start[2]), .din(din[2][7:0]),
    .o_tx_ready(ready[2]), .o_tx_busy(busy[2]),
    .o_tx_done(done[2]), .o_tx(tx[2])
  );

  function automatic int cfg_dw(input int k);
    return (k == 1) ? 7 : 8;
  endfunction

  function automatic int cfg_os(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 8);
  endfunction

  function automatic int cfg_pe(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int cfg_po(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_sb(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s: got %0h want %0h at %0t", tag, got, want,
                 $time);
    end
  endtask

  // Random baud ticks, changed away from the sampling edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2 baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic line_chk(input int k, input logic b);
    chk($sformatf("tx%0d", k), tx[k], b);
    chk($sformatf("busy%0d", k), busy[k], 1);
    chk($sformatf("ready%0d", k), ready[k], 0);
    chk($sformatf("done%0d", k), done[k], 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_tx%0d", k), tx[k], 1);
        chk($sformatf("idle_busy%0d", k), busy[k], 0);
        chk($sformatf("idle_done%0d", k), done[k], 0);
        chk($sformatf("idle_ready%0d", k), ready[k], 1);
      end
    end
  endtask

  // Called at a negedge with DUT k idle. abort_at >= 0 resets mid-frame.
  task automatic run_frame(input int k, input logic [8:0] d,
                           input bit hold, input int abort_at);
    logic exp_bits[$];
    int   os;
    int   nt;
    int   ones;
    int   w;
    os   = cfg_os(k);
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < cfg_dw(k); i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_pe(k) != 0)
      exp_bits.push_back(1'((ones % 2) ^ cfg_po(k)));
    for (int s = 0; s < cfg_sb(k); s++)
      exp_bits.push_back(1'b1);
    nt = exp_bits.size() * os;
    chk($sformatf("ready_pre%0d", k), ready[k], 1);
    start[k] = 1'b1;
    din[k]   = d;
    @(negedge clk);
    line_chk(k, 1'b0);
    if (!hold) start[k] = 1'b0;
    for (int t = 0; t < nt; t++) begin
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        chk($sformatf("rst_tx%0d", k), tx[k], 1);
        chk($sformatf("rst_busy%0d", k), busy[k], 0);
        chk($sformatf("rst_done%0d", k), done[k], 0);
        chk($sformatf("rst_ready%0d", k), ready[k], 1);
        start[k] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      w = 0;
      while (!baud_tick && w < 200) begin
        line_chk(k, exp_bits[t / os]);
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        chk("tick_timeout", 0, 1);
        start[k] = 1'b0;
        return;
      end
      line_chk(k, exp_bits[t / os]);
      if (!hold) start[k] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) din[k] = 9'($urandom);
      @(negedge clk);
    end
    chk($sformatf("end_done%0d", k), done[k], 1);
    chk($sformatf("end_busy%0d", k), busy[k], 0);
    chk($sformatf("end_tx%0d", k), tx[k], 1);
    chk($sformatf("end_ready%0d", k), ready[k], 1);
    start[k] = hold;
  endtask

  initial begin
    int         k;
    logic [8:0] d;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rv_tx%0d", i), tx[i], 1);
      chk($sformatf("rv_busy%0d", i), busy[i], 0);
      chk($sformatf("rv_done%0d", i), done[i], 0);
      chk($sformatf("rv_ready%0d", i), ready[i], 1);
    end
    rst = 1'b0;
    idle(2);

    run_frame(0, 9'h055, 1'b0, -1);
    idle(3);
    run_frame(2, 9'h007, 1'b0, -1);
    idle(2);
    run_frame(1, 9'h007, 1'b0, -1);
    run_frame(1, 9'h000, 1'b0, -1);
    idle(2);
    run_frame(0, 9'h0a3, 1'b0, -1);
    idle(2);
    run_frame(0, 9'h081, 1'b1, -1);
    run_frame(0, 9'h081, 1'b0, -1);
    idle(2);
    run_frame(0, 9'h03c, 1'b0, 16 * 4 + 8);
    idle(2);
    run_frame(0, 9'h096, 1'b0, -1);
    idle(2);
    run_frame(1, 9'h05a, 1'b0, 4 * 4 + 2);
    idle(2);
    run_frame(1, 9'h06d, 1'b0, -1);
    idle(2);

    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 2);
      d = 9'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        run_frame(k, d, 1'b1, -1);
        d = 9'($urandom);
        run_frame(k, d, 1'b0, -1);
      end else begin
        run_frame(k, d, 1'b0, -1);
      end
      idle($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
